// File: rtl/equiv_mon_pkg.sv
// Shared types and constants for the equivalence response monitor.
package equiv_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mon_state_e;

    localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
    localparam logic [31:0] MISR_SEED = 32'hFFFFFFFF;

    // Number of LANE_W-wide lanes needed to cover a Y_W-wide vector.
    function automatic int nlanes(input int y_w, input int lane_w);
        return (y_w + lane_w - 1) / lane_w;
    endfunction

endpackage

// File: rtl/equiv_response_monitor_misr_fold.sv
// Zero-pads a vector to whole lanes, XOR-folds the lanes, and advances a MISR by one step when enabled.
module misr_fold
    import equiv_mon_pkg::*;
#(
    parameter int               Y_W    = 924,
    parameter int               LANE_W = 32,
    parameter int               SIG_W  = 32,
    parameter logic [SIG_W-1:0] POLY   = MISR_POLY,
    parameter logic [SIG_W-1:0] SEED   = MISR_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [Y_W-1:0]   y,
    output logic [SIG_W-1:0] sig
);
    localparam int NLANE = nlanes(Y_W, LANE_W);
    localparam int PAD_W = NLANE * LANE_W;

    logic [PAD_W-1:0]  y_pad;
    logic [LANE_W-1:0] fold;
    logic [SIG_W-1:0]  sig_q, sig_d;

    assign y_pad = PAD_W'(y);

    // XOR of all lanes, then one shift/feedback step of the MISR.
    always_comb begin
        fold = '0;
        for (int i = 0; i < NLANE; i++) begin
            fold = fold ^ y_pad[i*LANE_W +: LANE_W];
        end
        sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold;
    end

    // Signature register: cleared on reset, seeded on run start, stepped per accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else if (load) begin
            sig_q <= SEED;
        end else if (en) begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/equiv_response_monitor.sv
// Compares golden and implementation output streams: run FSM, counters, first-mismatch locator, MISRs.
module equiv_response_monitor
    import equiv_mon_pkg::*;
#(
    parameter int               Y_W    = 924,
    parameter int               LANE_W = 32,
    parameter int               SIG_W  = 32,
    parameter logic [SIG_W-1:0] POLY   = MISR_POLY,
    parameter logic [SIG_W-1:0] SEED   = MISR_SEED,
    parameter int               CNT_W  = 16,
    localparam int              NLANE  = nlanes(Y_W, LANE_W),
    localparam int              LIDX_W = (NLANE > 1) ? $clog2(NLANE) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sample_valid,
    input  logic              sample_last,
    input  logic [Y_W-1:0]    y_gold,
    input  logic [Y_W-1:0]    y_impl,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  sample_count,
    output logic [CNT_W-1:0]  mismatch_count,
    output logic [CNT_W-1:0]  first_mismatch_cycle,
    output logic [LIDX_W-1:0] first_mismatch_lane,
    output logic [SIG_W-1:0]  sig_gold,
    output logic [SIG_W-1:0]  sig_impl
);
    localparam int PAD_W = NLANE * LANE_W;

    mon_state_e        state_q, state_d;
    logic              arm, accept;
    logic [PAD_W-1:0]  diff_pad;
    logic              any_diff;
    logic [LIDX_W-1:0] low_lane;

    logic [CNT_W-1:0]  sample_count_q, mismatch_count_q, first_cycle_q;
    logic [LIDX_W-1:0] first_lane_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; arming and sample acceptance are mutually exclusive, so start wins in DONE.
    always_comb begin
        state_d = state_q;
        arm     = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    arm     = 1'b1;
                end
            end
            RUN: begin
                if (sample_valid) begin
                    accept = 1'b1;
                    if (sample_last) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign diff_pad = PAD_W'(y_gold ^ y_impl);
    assign any_diff = |diff_pad;

    // Lowest lane with any differing bit; scanning downward lets the lowest hit win.
    always_comb begin
        low_lane = '0;
        for (int i = NLANE - 1; i >= 0; i--) begin
            if (|diff_pad[i*LANE_W +: LANE_W]) begin
                low_lane = LIDX_W'(i);
            end
        end
    end

    // Saturating counters; a zero mismatch count marks that no first mismatch has been latched yet.
    always_ff @(posedge clk) begin
        if (rst || arm) begin
            sample_count_q   <= '0;
            mismatch_count_q <= '0;
            first_cycle_q    <= '0;
            first_lane_q     <= '0;
        end else if (accept) begin
            if (sample_count_q != '1) begin
                sample_count_q <= sample_count_q + CNT_W'(1);
            end
            if (any_diff) begin
                if (mismatch_count_q != '1) begin
                    mismatch_count_q <= mismatch_count_q + CNT_W'(1);
                end
                if (mismatch_count_q == '0) begin
                    first_cycle_q <= sample_count_q;
                    first_lane_q  <= low_lane;
                end
            end
        end
    end

    misr_fold #(
        .Y_W(Y_W), .LANE_W(LANE_W), .SIG_W(SIG_W), .POLY(POLY), .SEED(SEED)
    ) u_misr_gold (
        .clk(clk), .rst(rst), .load(arm), .en(accept), .y(y_gold), .sig(sig_gold)
    );

    misr_fold #(
        .Y_W(Y_W), .LANE_W(LANE_W), .SIG_W(SIG_W), .POLY(POLY), .SEED(SEED)
    ) u_misr_impl (
        .clk(clk), .rst(rst), .load(arm), .en(accept), .y(y_impl), .sig(sig_impl)
    );

    assign busy                 = (state_q == RUN);
    assign done                 = (state_q == DONE);
    assign pass                 = (state_q == DONE) && (mismatch_count_q == '0);
    assign sample_count         = sample_count_q;
    assign mismatch_count       = mismatch_count_q;
    assign first_mismatch_cycle = first_cycle_q;
    assign first_mismatch_lane  = first_lane_q;

endmodule

// File: tb/tb_equiv_response_monitor.sv
// Bench for equiv_response_monitor: directed runs, behavioural model, per-cycle compare.
module tb_equiv_response_monitor;
    localparam int Y_W = 924;

    logic clk = 1'b0;
    logic rst, start, sample_valid, sample_last;
    logic [Y_W-1:0] y_gold, y_impl;

    logic        d_busy, d_done, d_pass;
    logic [15:0] d_sc, d_mc, d_fc;
    logic [4:0]  d_fl;
    logic [31:0] d_sg, d_si;

    logic        e_busy, e_done, e_pass;
    logic [3:0]  e_sc, e_mc, e_fc;
    logic [4:0]  e_fl;
    logic [31:0] e_sg, e_si;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    equiv_response_monitor dut (
        .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid), .sample_last(sample_last),
        .y_gold(y_gold), .y_impl(y_impl), .busy(d_busy), .done(d_done), .pass(d_pass),
        .sample_count(d_sc), .mismatch_count(d_mc), .first_mismatch_cycle(d_fc),
        .first_mismatch_lane(d_fl), .sig_gold(d_sg), .sig_impl(d_si)
    );

    equiv_response_monitor #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid), .sample_last(sample_last),
        .y_gold(y_gold), .y_impl(y_impl), .busy(e_busy), .done(e_done), .pass(e_pass),
        .sample_count(e_sc), .mismatch_count(e_mc), .first_mismatch_cycle(e_fc),
        .first_mismatch_lane(e_fl), .sig_gold(e_sg), .sig_impl(e_si)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Fold: bit b of the vector lands in signature bit (b mod 32); padding bits contribute nothing.
    function automatic logic [31:0] fold_of(input logic [Y_W-1:0] y);
        logic [31:0] f = '0;
        for (int b = 0; b < Y_W; b++) f[b % 32] = f[b % 32] ^ y[b];
        return f;
    endfunction

    function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] f);
        logic [31:0] r = (s << 1) ^ f;
        if (s[31]) r = r ^ 32'h04C11DB7;
        return r;
    endfunction

    function automatic longint sat(input longint v, input longint m);
        return (v > m) ? m : v;
    endfunction

    int          m_state = 0;   // 0 idle, 1 run, 2 done
    longint      m_sc = 0, m_mc = 0, m_fc = 0;
    int          m_fl = 0;
    logic [31:0] m_sg = '0, m_si = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0; m_sc = 0; m_mc = 0; m_fc = 0; m_fl = 0; m_sg = '0; m_si = '0;
        end else if (start && m_state != 1) begin
            m_state = 1; m_sc = 0; m_mc = 0; m_fc = 0; m_fl = 0;
            m_sg = 32'hFFFFFFFF; m_si = 32'hFFFFFFFF;
        end else if (m_state == 1 && sample_valid) begin
            m_sg = misr(m_sg, fold_of(y_gold));
            m_si = misr(m_si, fold_of(y_impl));
            if (y_gold !== y_impl) begin
                if (m_mc == 0) begin
                    int low = 0;
                    for (int b = Y_W - 1; b >= 0; b--) if (y_gold[b] !== y_impl[b]) low = b;
                    m_fc = m_sc;
                    m_fl = low / 32;
                end
                m_mc++;
            end
            m_sc++;
            if (sample_last) m_state = 2;
        end
    end

    // Compare both instances against the model every cycle.
    always @(negedge clk) begin
        check("busy",   d_busy, 64'(m_state == 1));
        check("done",   d_done, 64'(m_state == 2));
        check("pass",   d_pass, 64'(m_state == 2 && m_mc == 0));
        check("sc",     d_sc,   sat(m_sc, 65535));
        check("mc",     d_mc,   sat(m_mc, 65535));
        check("fc",     d_fc,   sat(m_fc, 65535));
        check("fl",     d_fl,   m_fl);
        check("sg",     d_sg,   m_sg);
        check("si",     d_si,   m_si);
        check("busy4",  e_busy, 64'(m_state == 1));
        check("done4",  e_done, 64'(m_state == 2));
        check("pass4",  e_pass, 64'(m_state == 2 && m_mc == 0));
        check("sc4",    e_sc,   sat(m_sc, 15));
        check("mc4",    e_mc,   sat(m_mc, 15));
        check("fc4",    e_fc,   sat(m_fc, 15));
        check("fl4",    e_fl,   m_fl);
        check("sg4",    e_sg,   m_sg);
        check("si4",    e_si,   m_si);
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic s, input logic v, input logic l,
                        input logic [Y_W-1:0] g, input logic [Y_W-1:0] im);
        rst = r; start = s; sample_valid = v; sample_last = l; y_gold = g; y_impl = im;
        @(negedge clk);
    endtask

    function automatic logic [Y_W-1:0] rand_vec();
        logic [1023:0] t;
        for (int i = 0; i < 32; i++) t[i*32 +: 32] = $urandom;
        return t[Y_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] bit_mask(input int b);
        logic [Y_W-1:0] m = '0;
        m[b] = 1'b1;
        return m;
    endfunction

    logic [Y_W-1:0] g;

    initial begin
        rst = 1'b1; start = 1'b0; sample_valid = 1'b0; sample_last = 1'b0;
        y_gold = '0; y_impl = '0;
        step(1, 0, 0, 0, '0, '0);
        step(1, 0, 0, 0, '0, '0);
        check("rst_busy", d_busy, 0);
        check("rst_sig",  d_sg, 0);

        // 1: single all-zero sample
        step(0, 1, 0, 0, '0, '0);
        step(0, 0, 1, 1, '0, '0);
        check("t1_done", d_done, 1);
        check("t1_pass", d_pass, 1);
        check("t1_sc",   d_sc, 1);
        check("t1_sg",   d_sg, 32'hFB3EE249);
        check("t1_si",   d_si, 32'hFB3EE249);

        // 2: 21 identical random samples
        step(0, 1, 0, 0, '0, '0);
        for (int k = 0; k < 21; k++) begin
            g = rand_vec();
            step(0, 0, 1, k == 20, g, g);
        end
        check("t2_pass", d_pass, 1);
        check("t2_mc",   d_mc, 0);
        check("t2_sc",   d_sc, 21);
        check("t2_sig",  d_si, m_sg);

        // 3: bit 100 flipped on sample 5
        step(0, 1, 0, 0, '0, '0);
        for (int k = 0; k < 21; k++) begin
            g = rand_vec();
            step(0, 0, 1, k == 20, g, (k == 5) ? (g ^ bit_mask(100)) : g);
        end
        check("t3_pass", d_pass, 0);
        check("t3_mc",   d_mc, 1);
        check("t3_fc",   d_fc, 5);
        check("t3_fl",   d_fl, 3);
        check("t3_sigdiff", 64'(d_sg != d_si), 1);

        // 4: bits 40 and 923 on sample 0, bit 0 on sample 7
        step(0, 1, 0, 0, '0, '0);
        for (int k = 0; k < 8; k++) begin
            g = rand_vec();
            if (k == 0)      step(0, 0, 1, 0, g, g ^ bit_mask(40) ^ bit_mask(923));
            else if (k == 7) step(0, 0, 1, 1, g, g ^ bit_mask(0));
            else             step(0, 0, 1, 0, g, g);
        end
        check("t4_mc", d_mc, 2);
        check("t4_fc", d_fc, 0);
        check("t4_fl", d_fl, 1);

        // 5: 20 mismatching samples, 4-bit counters saturate
        step(0, 1, 0, 0, '0, '0);
        for (int k = 0; k < 20; k++) begin
            g = rand_vec();
            step(0, 0, 1, k == 19, g, g ^ bit_mask($urandom_range(0, Y_W - 1)));
        end
        check("t5_mc4", e_mc, 15);
        check("t5_sc4", e_sc, 15);
        check("t5_mc",  d_mc, 20);

        // 6: reset mid-run, then start collides with a sample in DONE
        step(0, 1, 0, 0, '0, '0);
        for (int k = 0; k < 10; k++) begin
            g = rand_vec();
            step(0, 0, 1, 0, g, ~g);
        end
        g = rand_vec();
        step(1, 0, 1, 0, g, ~g);
        check("t6_busy", d_busy, 0);
        check("t6_done", d_done, 0);
        check("t6_sc",   d_sc, 0);
        check("t6_mc",   d_mc, 0);
        check("t6_fc",   d_fc, 0);
        check("t6_fl",   d_fl, 0);
        check("t6_sg",   d_sg, 0);
        check("t6_si",   d_si, 0);
        step(0, 1, 0, 0, '0, '0);
        g = rand_vec();
        step(0, 0, 1, 1, g, g);
        check("t6_done2", d_done, 1);
        step(0, 1, 1, 1, g, ~g);
        check("t6_rearm_busy", d_busy, 1);
        check("t6_rearm_sc",   d_sc, 0);
        check("t6_rearm_mc",   d_mc, 0);
        check("t6_rearm_sg",   d_sg, 32'hFFFFFFFF);
        step(0, 0, 0, 0, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
